// File: rtl/des_perm_pipe_pkg.sv
// Shared DES permutation definitions: mode encodings, the FP index table
// in LSB-0 numbering, and single-block IP / IP^-1 helpers.
package des_pkg;

  localparam logic [1:0] MODE_IP  = 2'b00;
  localparam logic [1:0] MODE_IIP = 2'b01;
  localparam logic [1:0] MODE_BYP = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  // FP_G[i] is the source bit of output bit i for IP^-1 (LSB-0 numbering).
  localparam logic [5:0] FP_G [64] = '{
    6'd39, 6'd7,  6'd47, 6'd15, 6'd55, 6'd23, 6'd63, 6'd31,
    6'd38, 6'd6,  6'd46, 6'd14, 6'd54, 6'd22, 6'd62, 6'd30,
    6'd37, 6'd5,  6'd45, 6'd13, 6'd53, 6'd21, 6'd61, 6'd29,
    6'd36, 6'd4,  6'd44, 6'd12, 6'd52, 6'd20, 6'd60, 6'd28,
    6'd35, 6'd3,  6'd43, 6'd11, 6'd51, 6'd19, 6'd59, 6'd27,
    6'd34, 6'd2,  6'd42, 6'd10, 6'd50, 6'd18, 6'd58, 6'd26,
    6'd33, 6'd1,  6'd41, 6'd9,  6'd49, 6'd17, 6'd57, 6'd25,
    6'd32, 6'd0,  6'd40, 6'd8,  6'd48, 6'd16, 6'd56, 6'd24
  };

  function automatic logic [63:0] des_iip64(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[i] = d[FP_G[i]];
    return r;
  endfunction

  function automatic logic [63:0] des_ip64(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) r[FP_G[i]] = d[i];
    return r;
  endfunction

endpackage

// File: rtl/des_perm_pipe_if.sv
// Valid/ready bus of the DES permutation pipe; the environment is the
// master and the pipe is the slave.
interface des_perm_pipe_if #(
  parameter int LANES = 1,
  parameter int CNT_W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_mode;
  logic [64*LANES-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [64*LANES-1:0]   out_data;
  logic                  out_err;
  logic [CNT_W-1:0]      xfer_cnt;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err, xfer_cnt
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err, xfer_cnt
  );
endinterface

// File: rtl/des_perm_lane.sv
// Combinational per-lane permutation: IP, IP^-1 or bypass on one 64-bit
// block; the reserved mode bypasses and raises err.
module des_perm_lane
  import des_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  mode,
  output logic [63:0] result,
  output logic        err
);

  always_comb begin
    result = data;
    err    = 1'b0;
    case (mode)
      MODE_IP:  result = des_ip64(data);
      MODE_IIP: result = des_iip64(data);
      MODE_RSV: err    = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/des_perm_pipe.sv
// Elastic pipeline around LANES parallel DES permutation lanes, with a
// saturating count of completed output transfers.
module des_perm_pipe
  import des_pkg::*;
#(
  parameter int LANES       = 1,
  parameter int PIPE_STAGES = 1,
  parameter int CNT_W       = 16
) (
  input  logic           clk,
  input  logic           reset,
  des_perm_pipe_if.slave bus
);

  localparam int W = 64 * LANES;

  if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
    $error("des_perm_pipe: PIPE_STAGES must be in 1..3");
  end

  logic [W-1:0]           mapped;
  logic [LANES-1:0]       lane_err;
  logic [W-1:0]           stage_data [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] stage_err;
  logic [PIPE_STAGES-1:0] stage_vld;
  logic [W-1:0]           src_data [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] src_err;
  logic [PIPE_STAGES-1:0] src_vld;
  logic [PIPE_STAGES-1:0] load;
  logic [CNT_W-1:0]       cnt;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    des_perm_lane u_lane (
      .data   (bus.in_data[64*k +: 64]),
      .mode   (bus.in_mode),
      .result (mapped[64*k +: 64]),
      .err    (lane_err[k])
    );
  end

  assign src_data[0] = mapped;
  assign src_err[0]  = |lane_err;
  assign src_vld[0]  = bus.in_valid;

  for (genvar s = 1; s < PIPE_STAGES; s++) begin : g_src
    assign src_data[s] = stage_data[s-1];
    assign src_err[s]  = stage_err[s-1];
    assign src_vld[s]  = stage_vld[s-1];
  end

  // A stage can load unless it and every stage after it are full and stalled.
  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_load
    assign load[s] = bus.out_ready || !(&stage_vld[PIPE_STAGES-1:s]);
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = stage_vld[PIPE_STAGES-1];
  assign bus.out_data  = stage_data[PIPE_STAGES-1];
  assign bus.out_err   = stage_err[PIPE_STAGES-1];
  assign bus.xfer_cnt  = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_vld <= '0;
      stage_err <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) stage_data[s] <= '0;
    end else begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        if (load[s]) begin
          stage_vld[s] <= src_vld[s];
          if (src_vld[s]) begin
            stage_data[s] <= src_data[s];
            stage_err[s]  <= src_err[s];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (bus.out_valid && bus.out_ready && cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed self-checking bench for des_perm_pipe across four parameter
// sets: mapping, round trip, backpressure, mid-stream reset, saturation.
module tb_des_perm_pipe;

  logic clk = 1'b0;
  logic reset;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  des_perm_pipe_if #(.LANES(1), .CNT_W(16)) if1 ();
  des_perm_pipe_if #(.LANES(2), .CNT_W(16)) if2 ();
  des_perm_pipe_if #(.LANES(1), .CNT_W(16)) if3 ();
  des_perm_pipe_if #(.LANES(1), .CNT_W(4))  if4 ();

  des_perm_pipe #(.LANES(1), .PIPE_STAGES(1), .CNT_W(16)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  des_perm_pipe #(.LANES(2), .PIPE_STAGES(3), .CNT_W(16)) u2 (.clk(clk), .reset(reset), .bus(if2.slave));
  des_perm_pipe #(.LANES(1), .PIPE_STAGES(2), .CNT_W(16)) u3 (.clk(clk), .reset(reset), .bus(if3.slave));
  des_perm_pipe #(.LANES(1), .PIPE_STAGES(1), .CNT_W(4))  u4 (.clk(clk), .reset(reset), .bus(if4.slave));

  task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  logic [1:0]   m1 [3];
  logic [63:0]  d1 [3];
  logic [63:0]  e1 [3];
  logic [127:0] orig [100];
  logic [127:0] ipd  [100];
  logic [127:0] byp_word;
  logic [127:0] rsv_word;
  logic [63:0]  w0, w1, w2, w3, w4;

  initial begin
    reset = 1'b1;
    if1.in_valid = 1'b0; if1.in_mode = 2'b00; if1.in_data = '0; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.in_mode = 2'b00; if2.in_data = '0; if2.out_ready = 1'b1;
    if3.in_valid = 1'b0; if3.in_mode = 2'b00; if3.in_data = '0; if3.out_ready = 1'b1;
    if4.in_valid = 1'b0; if4.in_mode = 2'b00; if4.in_data = '0; if4.out_ready = 1'b1;

    m1[0] = 2'b01; d1[0] = 64'h0000008000000000; e1[0] = 64'h0000000000000001;
    m1[1] = 2'b00; d1[1] = 64'h0000000000000001; e1[1] = 64'h0000008000000000;
    m1[2] = 2'b01; d1[2] = 64'h0000000000000001; e1[2] = 64'h0200000000000000;
    for (int i = 0; i < 100; i++) orig[i] = {$urandom, $urandom, $urandom, $urandom};
    byp_word = 128'h0123456789abcdef_fedcba9876543210;
    rsv_word = 128'hdeadbeefcafef00d_5a5aa5a50f0ff0f0;
    w0 = 64'h1111111111111111; w1 = 64'h2222222222222222; w2 = 64'h3333333333333333;
    w3 = 64'h4444444444444444; w4 = 64'h5555555555555555;

    // reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_output("rst_out_valid", if1.out_valid, 1'b0);
    check_output("rst_out_data", if1.out_data, 64'h0);
    check_output("rst_out_err", if1.out_err, 1'b0);
    check_output("rst_xfer_cnt", if1.xfer_cnt, 16'h0);
    check_output("rst_in_ready", if1.in_ready, 1'b1);
    check_output("rst_in_ready_u2", if2.in_ready, 1'b1);

    // single-lane directed mapping, latency 1
    for (int i = 0; i < 3; i++) begin
      if1.in_valid = 1'b1; if1.in_mode = m1[i]; if1.in_data = d1[i];
      @(negedge clk);
      if1.in_valid = 1'b0;
      check_output("map_valid", if1.out_valid, 1'b1);
      check_output("map_data", if1.out_data, e1[i]);
      check_output("map_err", if1.out_err, 1'b0);
    end
    @(negedge clk);
    check_output("map_idle_valid", if1.out_valid, 1'b0);
    check_output("map_cnt", if1.xfer_cnt, 16'd3);

    // round trip: IP pass, then IP^-1 pass on the captured outputs
    for (int c = 0; c < 103; c++) begin
      if (c < 100) begin
        if2.in_valid = 1'b1; if2.in_mode = 2'b00; if2.in_data = orig[c];
        check_output("rt_ip_in_ready", if2.in_ready, 1'b1);
      end else begin
        if2.in_valid = 1'b0;
      end
      if (c >= 3) begin
        check_output("rt_ip_valid", if2.out_valid, 1'b1);
        ipd[c-3] = if2.out_data;
      end else begin
        check_output("rt_ip_latency", if2.out_valid, 1'b0);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 103; c++) begin
      if (c < 100) begin
        if2.in_valid = 1'b1; if2.in_mode = 2'b01; if2.in_data = ipd[c];
      end else begin
        if2.in_valid = 1'b0;
      end
      if (c >= 3) begin
        check_output("rt_iip_valid", if2.out_valid, 1'b1);
        check_output("rt_iip_data", if2.out_data, orig[c-3]);
      end else begin
        check_output("rt_iip_latency", if2.out_valid, 1'b0);
      end
      @(negedge clk);
    end
    check_output("rt_cnt", if2.xfer_cnt, 16'd200);

    // bypass and reserved modes on two lanes
    if2.in_valid = 1'b1; if2.in_mode = 2'b10; if2.in_data = byp_word;
    @(negedge clk);
    if2.in_mode = 2'b11; if2.in_data = rsv_word;
    @(negedge clk);
    if2.in_valid = 1'b0;
    @(negedge clk);
    check_output("byp_data", if2.out_data, byp_word);
    check_output("byp_err", if2.out_err, 1'b0);
    @(negedge clk);
    check_output("rsv_valid", if2.out_valid, 1'b1);
    check_output("rsv_data", if2.out_data, rsv_word);
    check_output("rsv_err", if2.out_err, 1'b1);
    @(negedge clk);
    check_output("rsv_drain", if2.out_valid, 1'b0);

    // backpressure on the two-stage pipe
    if3.out_ready = 1'b0; if3.in_mode = 2'b10;
    if3.in_valid = 1'b1; if3.in_data = w0;
    check_output("bp_ready0", if3.in_ready, 1'b1);
    @(negedge clk);
    if3.in_data = w1;
    check_output("bp_ready1", if3.in_ready, 1'b1);
    check_output("bp_valid1", if3.out_valid, 1'b0);
    @(negedge clk);
    if3.in_data = w2;
    for (int c = 2; c < 5; c++) begin
      check_output("bp_ready_low", if3.in_ready, 1'b0);
      check_output("bp_valid_hold", if3.out_valid, 1'b1);
      check_output("bp_data_hold", if3.out_data, w0);
      @(negedge clk);
    end
    if3.in_valid = 1'b0; if3.out_ready = 1'b1;
    check_output("bp_rel_w0", if3.out_data, w0);
    @(negedge clk);
    check_output("bp_rel_valid", if3.out_valid, 1'b1);
    check_output("bp_rel_w1", if3.out_data, w1);
    @(negedge clk);
    check_output("bp_no_w2", if3.out_valid, 1'b0);
    check_output("bp_cnt", if3.xfer_cnt, 16'd2);
    @(negedge clk);
    check_output("bp_no_w2_late", if3.out_valid, 1'b0);

    // reset with two words in flight
    if3.out_ready = 1'b0;
    if3.in_valid = 1'b1; if3.in_data = w3;
    @(negedge clk);
    if3.in_data = w4;
    @(negedge clk);
    if3.in_valid = 1'b0;
    check_output("mid_full", if3.out_valid, 1'b1);
    reset = 1'b1; if3.out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_output("mid_rst_valid", if3.out_valid, 1'b0);
    check_output("mid_rst_cnt", if3.xfer_cnt, 16'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_output("mid_rst_gone", if3.out_valid, 1'b0);
    end

    // counter saturation with a 4-bit counter
    if4.in_mode = 2'b10;
    for (int c = 0; c < 22; c++) begin
      if (c < 20) begin
        if4.in_valid = 1'b1; if4.in_data = 64'(c);
      end else begin
        if4.in_valid = 1'b0;
      end
      if (c == 10) check_output("sat_data", if4.out_data, 64'd9);
      if (c == 15) check_output("sat_cnt14", if4.xfer_cnt, 4'd14);
      if (c == 16) check_output("sat_cnt15", if4.xfer_cnt, 4'd15);
      @(negedge clk);
    end
    check_output("sat_final_cnt", if4.xfer_cnt, 4'd15);
    check_output("sat_final_valid", if4.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/des_perm_pipe.md
Name: des_perm_pipe

Overview:
- Parametrised, pipelined successor to the fixed combinational DES inverse initial permutation.
- Applies the DES initial permutation (IP), its inverse (IP^-1) or bypass to LANES parallel 64-bit blocks. The mode is selected per transaction.
- Sits between the round datapath and the block I/O, behind a valid/ready handshake, with configurable pipeline depth and a saturating completed-transfer counter.

Parameters:
- LANES, 1, number of 64-bit blocks processed per transfer; data width is 64*LANES.
- PIPE_STAGES, 1, register stages between input and output; legal range 1..3; latency equals PIPE_STAGES.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  in  1  clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input transfer is offered.
- in_ready  out  1  block accepts the input transfer this cycle.
- in_mode  in  2  00 = IP, 01 = IP^-1, 10 = bypass, 11 = reserved.
- in_data  in  64*LANES  lane k occupies bits [64k+63:64k].
- out_valid  out  1  output transfer is offered.
- out_ready  in  1  downstream accepts the output transfer.
- out_data  out  64*LANES  permuted lanes.
- out_err  out  1  output word was issued with the reserved mode.
- xfer_cnt  out  CNT_W  number of completed output transfers, saturating.

Behaviour:
- Reset. Clears all stage valid bits, stage data, the err bits and xfer_cnt. After reset: out_valid=0, out_data=0, out_err=0, xfer_cnt=0, in_ready=1.
- Reset mid-operation. Every in-flight word is discarded and no output is produced for it.
- Permutation mapping, per lane.
  - IP^-1: out[i] = in[g(i)], using the standard DES FP table in LSB-0 numbering, e.g. g(0)=39, g(57)=0, g(63)=24.
  - IP: out[g(i)] = in[i], the exact inverse of IP^-1.
  - Bypass: out = in.
  - Reserved (11): data passes as bypass, and err=1 travels with the word.
- All lanes use the same mode.
- Stage structure.
  - The mapping is applied combinationally before stage 0.
  - Stages 1..PIPE_STAGES-1 carry data and err unchanged.
  - Each stage holds data, err and valid.
- Handshake rules.
  - A stage loads when it is empty, or when its downstream neighbour takes its contents in the same cycle.
  - The last stage's downstream "take" is out_valid && out_ready.
  - in_ready is combinational from the pipeline state and out_ready. There is no combinational path from in_valid to in_ready.
  - An input transfer occurs when in_valid && in_ready; the word is captured into stage 0 at that edge.
- Throughput. With out_ready held at 1, one transfer is accepted every cycle; the first output appears PIPE_STAGES cycles after acceptance.
- Backpressure.
  - While out_ready=0 with out_valid=1, out_data and out_err stay stable.
  - The pipeline fills, then in_ready falls once all PIPE_STAGES stages are valid.
  - No word is dropped or duplicated.
- Simultaneous accept and emit in a full pipe. Legal: every stage shifts and occupancy stays constant.
- xfer_cnt.
  - Increments by 1 on each out_valid && out_ready.
  - Holds at 2^CNT_W-1 once reached; it does not wrap.
- Protocol rules.
  - An upstream that drops in_valid before acceptance is legal; the word is simply not taken.
  - in_mode and in_data are sampled only at the transfer edge.
- An out-of-range PIPE_STAGES is an elaboration error, enforced by a generate-time check.

Decomposition:
- Shared package des_pkg:
  - mode constants MODE_IP, MODE_IIP, MODE_BYP, MODE_RSV;
  - the 64-entry FP index table as a localparam array;
  - functions des_ip64 and des_iip64 operating on one 64-bit block.
- One sub-module, des_perm_lane. It is combinational: one 64-bit lane plus mode in, permuted lane plus err out. It is instantiated LANES times in a generate loop.
- The top level owns the elastic pipeline registers and the counter.

Test Plan:
- Reset, then idle. Check out_valid=0, out_data=0, xfer_cnt=0 and in_ready=1.
- Single-lane mapping (LANES=1, PIPE_STAGES=1), out_ready held 1:
  - mode 01, data 0x0000008000000000 -> 0x0000000000000001 after 1 cycle;
  - mode 00, data 0x0000000000000001 -> 0x0000008000000000;
  - mode 01, data 0x0000000000000001 -> 0x0200000000000000.
- Round trip and modes (LANES=2, PIPE_STAGES=3):
  - 100 random blocks through mode 00, then the outputs fed back with mode 01, reproduce the originals; latency is 3 and throughput is 1 per cycle.
  - mode 10 passes data unchanged.
  - mode 11 passes data unchanged with out_err=1.
- Backpressure (PIPE_STAGES=2):
  - out_ready=0 for 5 cycles while in_valid=1 -> in_ready falls after 2 accepts and out_data is stable.
  - On release, the words emerge in order with none lost.
- Reset mid-stream with 2 words in flight -> the next cycle shows out_valid=0 and xfer_cnt=0, and neither word ever appears.
- Counter saturation (CNT_W=4): 20 transfers -> xfer_cnt stops at 15.
